// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - shared function and sequencer state encodings
package alu_defs;

  typedef enum logic [1:0] {
    FN_AND = 2'd0,
    FN_OR  = 2'd1,
    FN_XOR = 2'd2,
    FN_NOT = 2'd3
  } fn_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/response bus between a requester and alu_seq
interface alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_fn;
  logic        req_wide;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_s;
  logic        rsp_v;
  logic        rsp_n;
  logic        rsp_z;

  modport slave (
    input  req_valid, req_fn, req_wide, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_s, rsp_v, rsp_n, rsp_z
  );

  modport master (
    output req_valid, req_fn, req_wide, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_s, rsp_v, rsp_n, rsp_z
  );
endinterface

// File: rtl/alu_logic.sv
// rtl/alu_logic.sv - 8-bit combinational logic unit sequenced by alu_seq
// Logic ops never overflow, so v is 0 and s reduces to the sign bit.
module alu_logic
  import alu_defs::*;
(
  input  logic [1:0] fn,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       s,
  output logic       v,
  output logic       n,
  output logic       z
);

  always_comb begin
    sum = 8'h00;
    case (fn_e'(fn))
      FN_AND:  sum = a & b;
      FN_OR:   sum = a | b;
      FN_XOR:  sum = a ^ b;
      FN_NOT:  sum = ~a;
      default: sum = 8'h00;
    endcase
  end

  assign n = sum[7];
  assign v = 1'b0;
  assign s = n ^ v;
  assign z = (sum == 8'h00);

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - runs byte/word logic ops through an 8-bit unit, holds result and flags
module alu_seq
  import alu_defs::*;
#(
  parameter bit WIDE_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus,
  output logic       flag_s,
  output logic       flag_v,
  output logic       flag_n,
  output logic       flag_z,
  output logic       busy,
  output logic [1:0] alu_fn,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_sum,
  input  logic       alu_s,
  input  logic       alu_v,
  input  logic       alu_n,
  input  logic       alu_z
);

  state_e      state;
  state_e      state_nx;

  logic [1:0]  fn_r;
  logic        wide_r;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [7:0]  res_lo;
  logic        z_lo;

  logic [15:0] result_q;
  logic        s_q, v_q, n_q, z_q;

  logic        load;
  logic [15:0] nx_result;
  logic        nx_z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    alu_fn   = 2'b00;
    alu_a    = 8'h00;
    alu_b    = 8'h00;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) state_nx = ST_LO;
      end
      ST_LO: begin
        alu_fn   = fn_r;
        alu_a    = a_r[7:0];
        alu_b    = b_r[7:0];
        state_nx = wide_r ? ST_HI : ST_DONE;
      end
      ST_HI: begin
        alu_fn   = fn_r;
        alu_a    = a_r[15:8];
        alu_b    = b_r[15:8];
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (bus.rsp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // The final pass (LO for bytes, HI for words) supplies s/v/n; a word is zero only if both halves are.
  always_comb begin
    load      = 1'b0;
    nx_result = 16'h0000;
    nx_z      = alu_z;
    if (state == ST_LO && !wide_r) begin
      load      = 1'b1;
      nx_result = {8'h00, alu_sum};
    end else if (state == ST_HI) begin
      load      = 1'b1;
      nx_result = {alu_sum, res_lo};
      nx_z      = z_lo & alu_z;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fn_r     <= 2'b00;
      wide_r   <= 1'b0;
      a_r      <= 16'h0000;
      b_r      <= 16'h0000;
      res_lo   <= 8'h00;
      z_lo     <= 1'b0;
      result_q <= 16'h0000;
      s_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      flag_s   <= 1'b0;
      flag_v   <= 1'b0;
      flag_n   <= 1'b0;
      flag_z   <= 1'b0;
    end else begin
      if (state == ST_IDLE && bus.req_valid) begin
        fn_r   <= bus.req_fn;
        wide_r <= bus.req_wide & WIDE_EN;
        a_r    <= bus.req_a;
        b_r    <= bus.req_b;
      end
      if (state == ST_LO) begin
        res_lo <= alu_sum;
        z_lo   <= alu_z;
      end
      if (load) begin
        result_q <= nx_result;
        s_q      <= alu_s;
        v_q      <= alu_v;
        n_q      <= alu_n;
        z_q      <= nx_z;
        flag_s   <= alu_s;
        flag_v   <= alu_v;
        flag_n   <= alu_n;
        flag_z   <= nx_z;
      end
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.rsp_valid  = (state == ST_DONE);
  assign bus.rsp_result = result_q;
  assign bus.rsp_s      = s_q;
  assign bus.rsp_v      = v_q;
  assign bus.rsp_n      = n_q;
  assign bus.rsp_z      = z_q;
  assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed and random checks of alu_seq against a 16-bit reference model
module tb_alu_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  alu_seq_if bus0();
  alu_seq_if bus1();

  logic       f0_s, f0_v, f0_n, f0_z, busy0;
  logic [1:0] fn0;
  logic [7:0] a0, b0, sum0;
  logic       s0, v0, n0, z0;

  logic       f1_s, f1_v, f1_n, f1_z, busy1;
  logic [1:0] fn1;
  logic [7:0] a1, b1, sum1;
  logic       s1, v1, n1, z1;

  alu_seq #(.WIDE_EN(1'b1)) u0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .flag_s(f0_s), .flag_v(f0_v), .flag_n(f0_n), .flag_z(f0_z), .busy(busy0),
    .alu_fn(fn0), .alu_a(a0), .alu_b(b0), .alu_sum(sum0),
    .alu_s(s0), .alu_v(v0), .alu_n(n0), .alu_z(z0)
  );
  alu_logic l0 (.fn(fn0), .a(a0), .b(b0), .sum(sum0), .s(s0), .v(v0), .n(n0), .z(z0));

  alu_seq #(.WIDE_EN(1'b0)) u1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .flag_s(f1_s), .flag_v(f1_v), .flag_n(f1_n), .flag_z(f1_z), .busy(busy1),
    .alu_fn(fn1), .alu_a(a1), .alu_b(b1), .alu_sum(sum1),
    .alu_s(s1), .alu_v(v1), .alu_n(n1), .alu_z(z1)
  );
  alu_logic l1 (.fn(fn1), .a(a1), .b(b1), .sum(sum1), .s(s1), .v(v1), .n(n1), .z(z1));

  // Returns {s, v, n, z, result} from plain 16-bit arithmetic.
  function automatic logic [19:0] model(input logic [1:0] fn, input logic wide,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic n;
    case (fn)
      2'd0:    r = a & b;
      2'd1:    r = a | b;
      2'd2:    r = a ^ b;
      default: r = ~a;
    endcase
    if (!wide) r = r & 16'h00FF;
    n = wide ? r[15] : r[7];
    return {n, 1'b0, n, (r == 16'h0000), r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] fn, input logic wide,
                          input logic [15:0] a, input logic [15:0] b);
    bus0.req_fn = fn; bus0.req_wide = wide; bus0.req_a = a; bus0.req_b = b;
    bus0.req_valid = 1'b1;
    chk("req_ready_idle", 32'(bus0.req_ready), 32'd1);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    chk("busy_after_accept", 32'(busy0), 32'd1);
  endtask

  // Entered at the first negedge after acceptance; leaves one negedge after the response handshake.
  task automatic finish_op(input logic [1:0] fn, input logic wide,
                           input logic [15:0] a, input logic [15:0] b, input int stall,
                           input bit queue_next, input logic [1:0] nfn, input logic [15:0] na);
    logic [19:0] exp;
    logic [15:0] held;
    int cnt;
    exp = model(fn, wide, a, b);
    cnt = 1;
    chk("alu_a_lo", 32'(a0), 32'(a[7:0]));
    chk("alu_b_lo", 32'(b0), 32'(b[7:0]));
    while (!bus0.rsp_valid && cnt < 8) begin
      @(negedge clk);
      cnt++;
      if (wide && cnt == 2) chk("alu_a_hi", 32'(a0), 32'(a[15:8]));
    end
    chk("latency", cnt, wide ? 3 : 2);
    chk("rsp_result", 32'(bus0.rsp_result), 32'(exp[15:0]));
    chk("rsp_flags", 32'({bus0.rsp_s, bus0.rsp_v, bus0.rsp_n, bus0.rsp_z}), 32'(exp[19:16]));
    chk("flag_reg_at_valid", 32'({f0_s, f0_v, f0_n, f0_z}), 32'(exp[19:16]));
    chk("alu_a_done", 32'(a0), 32'd0);
    held = bus0.rsp_result;
    if (queue_next) begin
      bus0.req_fn = nfn; bus0.req_wide = 1'b0; bus0.req_a = na; bus0.req_b = 16'h0000;
      bus0.req_valid = 1'b1;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus0.rsp_valid), 32'd1);
      chk("stall_result", 32'(bus0.rsp_result), 32'(held));
      chk("stall_req_ready", 32'(bus0.req_ready), 32'd0);
    end
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    bus0.rsp_ready = 1'b0;
    chk("valid_drop", 32'(bus0.rsp_valid), 32'd0);
    chk("ready_back", 32'(bus0.req_ready), 32'd1);
    chk("busy_idle", 32'(busy0), 32'd0);
    chk("result_hold", 32'(bus0.rsp_result), 32'(exp[15:0]));
    chk("flag_reg_hold", 32'({f0_s, f0_v, f0_n, f0_z}), 32'(exp[19:16]));
  endtask

  task automatic run_op(input logic [1:0] fn, input logic wide,
                        input logic [15:0] a, input logic [15:0] b, input int stall);
    start_op(fn, wide, a, b);
    finish_op(fn, wide, a, b, stall, 1'b0, 2'd0, 16'h0000);
  endtask

  initial begin
    logic [1:0]  rfn;
    logic        rwide;
    logic [15:0] ra, rb;
    int cnt;

    bus0.req_valid = 1'b0; bus0.req_fn = 2'd0; bus0.req_wide = 1'b0;
    bus0.req_a = 16'h0; bus0.req_b = 16'h0; bus0.rsp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_fn = 2'd0; bus1.req_wide = 1'b0;
    bus1.req_a = 16'h0; bus1.req_b = 16'h0; bus1.rsp_ready = 1'b1;

    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("rst_result", 32'(bus0.rsp_result), 32'd0);
    chk("rst_flags", 32'({f0_s, f0_v, f0_n, f0_z, bus0.rsp_s, bus0.rsp_v, bus0.rsp_n, bus0.rsp_z}), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_req_ready", 32'(bus0.req_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    run_op(2'd0, 1'b0, 16'h00F0, 16'h003C, 0);
    run_op(2'd2, 1'b1, 16'hA55A, 16'hA55A, 0);
    run_op(2'd1, 1'b1, 16'h8000, 16'h0000, 1);

    // Backpressure with a second request arriving while the result is held.
    start_op(2'd3, 1'b0, 16'h000F, 16'h0000);
    finish_op(2'd3, 1'b0, 16'h000F, 16'h0000, 5, 1'b1, 2'd1, 16'h0081);
    chk("queued_not_taken_in_done", 32'(bus0.req_valid & busy0), 32'd0);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    chk("queued_accepted", 32'(busy0), 32'd1);
    finish_op(2'd1, 1'b0, 16'h0081, 16'h0000, 0, 1'b0, 2'd0, 16'h0000);

    // Reset while the high byte is in flight.
    start_op(2'd1, 1'b1, 16'h1234, 16'h8001);
    @(negedge clk);
    chk("in_hi_alu_a", 32'(a0), 32'h12);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_ready", 32'(bus0.req_ready), 32'd1);
    chk("mid_rst_result", 32'(bus0.rsp_result), 32'd0);
    chk("mid_rst_flags", 32'({f0_s, f0_v, f0_n, f0_z}), 32'd0);
    chk("mid_rst_alu_a", 32'(a0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'({bus0.rsp_valid, busy0}), 32'd0);
      chk("post_rst_flags", 32'({f0_s, f0_v, f0_n, f0_z}), 32'd0);
    end
    run_op(2'd0, 1'b1, 16'hFF0F, 16'h80F0, 0);

    for (int k = 0; k < 24; k++) begin
      rfn   = 2'($urandom_range(0, 3));
      rwide = 1'($urandom_range(0, 1));
      ra    = 16'($urandom);
      rb    = (k % 5 == 0) ? ra : 16'($urandom);
      run_op(rfn, rwide, ra, rb, $urandom_range(0, 2));
    end

    // WIDE_EN=0: a wide request is run as a byte op.
    bus1.req_fn = 2'd0; bus1.req_wide = 1'b1; bus1.req_a = 16'hFFFF; bus1.req_b = 16'h00FF;
    bus1.req_valid = 1'b1;
    @(negedge clk);
    bus1.req_valid = 1'b0;
    cnt = 1;
    while (!bus1.rsp_valid && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    chk("narrow_latency", cnt, 2);
    chk("narrow_result", 32'(bus1.rsp_result), 32'h00FF);
    chk("narrow_flags", 32'({bus1.rsp_s, bus1.rsp_v, bus1.rsp_n, bus1.rsp_z}), 32'(4'b1010));
    @(negedge clk);
    chk("narrow_done", 32'({bus1.rsp_valid, busy1}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Controller that sequences the 8-bit combinational logic unit (fn/a/b in, sum plus s/v/n/z out) for byte and 16-bit word operations.
- Accepts one operation at a time over a valid/ready request port.
- Runs a word operation as two byte passes, low byte then high byte.
- Combines per-byte flags, holds the result until consumed, and keeps a persistent flag register for the CPU's branch logic.

Parameters:
WIDE_EN, 1, 1 = req_wide honoured; 0 = every request treated as byte (result[15:8] = 0).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_fn  input  2  logic function: 0 AND, 1 OR, 2 XOR, 3 NOT a
req_wide  input  1  1 = 16-bit operation, 0 = 8-bit
req_a  input  16  operand a (byte ops use [7:0])
req_b  input  16  operand b (byte ops use [7:0])
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_result  output  16  result
rsp_s, rsp_v, rsp_n, rsp_z  output  1 each  flags of this result
flag_s, flag_v, flag_n, flag_z  output  1 each  persistent flag register
busy  output  1  state != IDLE
alu_fn  output  2  to logic unit fn
alu_a, alu_b  output  8 each  to logic unit a, b
alu_sum  input  8  from logic unit sum
alu_s, alu_v, alu_n, alu_z  input  1 each  flags from logic unit

Behaviour:
- States: IDLE, LO, HI, DONE.
- Reset (asynchronous, active-high) forces IDLE from any state, including mid-operation. The in-flight operation is discarded; no response is produced.
- Reset values: rsp_valid=0, rsp_result=0, all rsp_* and flag_* =0, busy=0, req_ready=1.
- alu_fn/a/b are 0 in IDLE and DONE.
- IDLE: req_ready=1.
  - On req_valid, capture fn, wide (ANDed with WIDE_EN), a and b into registers; go to LO.
  - The request is not acknowledged while in any other state.
- LO:
  - Drive alu_fn=fn_r, alu_a=a_r[7:0], alu_b=b_r[7:0].
  - At the clock edge, capture alu_sum into res_lo and alu_z into z_lo.
  - Go to HI if wide_r, else DONE.
- HI:
  - Drive alu_a=a_r[15:8], alu_b=b_r[15:8].
  - Capture alu_sum into res_hi; go to DONE.
- Flag combination, registered on entry to DONE:
  - Byte: s=alu_s, n=alu_n, v=alu_v, z=alu_z, result={8'h00, lo}.
  - Word: s, n and v taken from the HI pass; z = z_lo & alu_z(HI); result={hi, lo}.
- The flag register (flag_*) loads the same values on the same edge that rsp_valid rises. It holds until the next completed operation; it is not altered by reset-free idling.
- DONE:
  - rsp_valid=1; rsp_result and rsp_* stay stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE. rsp_valid falls next cycle; rsp_result and rsp_* hold their last value.
- Latency from accept edge to rsp_valid high: byte 2 cycles, word 3 cycles.
- Throughput: one request per 3 (byte) / 4 (word) cycles when rsp_ready is held high. No back-to-back acceptance in DONE.
- Simultaneous rsp_ready and a new req_valid in DONE: the request waits; it is accepted in the following IDLE cycle.
- req_fn is 2 bits, so no illegal function codes exist. Operand bits above 7 are ignored for byte ops.

Decomposition:
- Shared package/header alu_defs holds:
  - the fn encodings FN_AND=0, FN_OR=1, FN_XOR=2, FN_NOT=3;
  - the state encodings ST_IDLE, ST_LO, ST_HI, ST_DONE (2 bits).
- No sub-module. The flag combination is a few gates inside alu_seq, and the logic unit is instantiated beside it at CPU level.
- The bench instantiates both.

Test Plan:
- Byte AND: fn=0, a=16'h00F0, b=16'h003C, wide=0.
  -> rsp_valid 2 cycles after accept; result=16'h0030; z=0, n=0; flag_z=0.
- Word XOR zero: fn=2, a=b=16'hA55A, wide=1.
  -> rsp_valid after 3 cycles; result=16'h0000; z=1, n=0.
  -> alu_a observed as 8'h5A in LO, then 8'hA5 in HI.
- Word OR, low byte zero, high byte nonzero: a=16'h8000, b=16'h0000.
  -> result=16'h8000; z=0 (only the low byte is zero); n=1, s=1.
- Backpressure: byte NOT a=8'h0F, with rsp_ready held low 5 cycles.
  -> result=16'h00F0, n=1, stable for all 5 cycles; req_ready=0 throughout.
  -> A second req_valid in that window is accepted only one cycle after rsp_ready.
- Reset mid-word: assert reset during HI.
  -> all outputs return to reset values immediately; flag_* stay 0; no rsp_valid.
  -> Next request completes normally.
- WIDE_EN=0 instance: wide=1, a=16'hFFFF, b=16'h00FF, fn=0.
  -> only the LO pass runs (2-cycle latency); result=16'h00FF.
